// File: rtl/cmp_minmax_seq.sv
// Burst min/max tracker: one comparator scans COUNT samples for extremes.
// Optional CMP_TIE_LAST_EN: equal samples move the index to the latest beat.
module cmp_minmax_seq #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4,
  localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDXW-1:0]  max_idx,
  output logic [IDXW-1:0]  min_idx
);

  typedef enum logic [1:0] {
    IDLE, FIRST, RUN, DONE
  } state_t;

  localparam int LAST = COUNT - 1;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDXW-1:0]  maxi_q, maxi_d;
  logic [IDXW-1:0]  mini_q, mini_d;
  logic [IDXW:0]    cnt_q, cnt_d;

  logic acc;
  logic gt_max, eq_max, lt_min, eq_min;
  logic upd_max, upd_min;

  // Shared compare unit: sample vs current max and current min.
  always_comb begin
    gt_max = in_data > max_q;
    eq_max = in_data == max_q;
    lt_min = in_data < min_q;
    eq_min = in_data == min_q;
`ifdef CMP_TIE_LAST_EN
    upd_max = gt_max || eq_max;
    upd_min = lt_min || eq_min;
`else
    upd_max = gt_max;
    upd_min = lt_min;
`endif
  end

  assign acc = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    maxi_d  = maxi_q;
    mini_d  = mini_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FIRST;
      end
      FIRST: begin
        if (acc) begin
          max_d   = in_data;
          min_d   = in_data;
          maxi_d  = '0;
          mini_d  = '0;
          cnt_d   = {{IDXW{1'b0}}, 1'b1};
          state_d = (COUNT == 1) ? DONE : RUN;
        end
      end
      RUN: begin
        if (acc) begin
          if (upd_max) begin
            max_d  = in_data;
            maxi_d = cnt_q[IDXW-1:0];
          end
          if (upd_min) begin
            min_d  = in_data;
            mini_d = cnt_q[IDXW-1:0];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST[IDXW:0]) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == FIRST) || (state_d == RUN);
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      max_q      <= '0;
      min_q      <= '0;
      maxi_q     <= '0;
      mini_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      max_q      <= max_d;
      min_q      <= min_d;
      maxi_q     <= maxi_d;
      mini_q     <= mini_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = maxi_q;
  assign min_idx  = mini_q;

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed bench for cmp_minmax_seq: COUNT=4 bursts plus a COUNT=1 instance.
// Expectations follow CMP_TIE_LAST_EN when the bench is built with it.
module tb_cmp_minmax_seq;

`ifdef CMP_TIE_LAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready, busy, done;
  logic [3:0] max_val, min_val;
  logic [1:0] max_idx, min_idx;

  logic       start1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [3:0] in_data1 = '0;
  logic       in_ready1, busy1, done1;
  logic [3:0] max_val1, min_val1;
  logic       max_idx1, min_idx1;

  always #5 clk = ~clk;

  cmp_minmax_seq #(.WIDTH(4), .COUNT(4)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done),
    .max_val(max_val), .min_val(min_val),
    .max_idx(max_idx), .min_idx(min_idx)
  );

  cmp_minmax_seq #(.WIDTH(4), .COUNT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .busy(busy1), .done(done1),
    .max_val(max_val1), .min_val(min_val1),
    .max_idx(max_idx1), .min_idx(min_idx1)
  );

  typedef struct {
    logic [3:0][3:0] d;
    int              gap_at;
    int              gap_len;
    bit              poke;
    logic [3:0]      gmax, gmin;
    logic [3:0]      emax, emin;
    logic [1:0]      emaxi, emini;
  } vec_t;

  vec_t tbl[4];
  int   n_chk = 0;
  int   n_fail = 0;
  int   dcnt = 0;

  always @(posedge clk) if (done) dcnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int k);
    vec_t v;
    v = tbl[k];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_ready", 32'(in_ready), 1);
    chk("first_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v.d[i];
      if (v.poke && i == 2) start = 1'b1;
      step();
      start = 1'b0;
      if (i < 3) chk("early_done", 32'(done), 0);
      if (i == v.gap_at) begin
        in_valid = 1'b0;
        in_data  = 4'd15;
        repeat (v.gap_len) begin
          step();
          chk("gap_max", 32'(max_val), 32'(v.gmax));
          chk("gap_min", 32'(min_val), 32'(v.gmin));
          chk("gap_done", 32'(done), 0);
        end
      end
    end
    in_valid = 1'b0;
    chk("done", 32'(done), 1);
    chk("max_val", 32'(max_val), 32'(v.emax));
    chk("max_idx", 32'(max_idx), 32'(v.emaxi));
    chk("min_val", 32'(min_val), 32'(v.emin));
    chk("min_idx", 32'(min_idx), 32'(v.emini));
    chk("done_ready", 32'(in_ready), 0);
    chk("done_busy", 32'(busy), 1);
    if (v.poke) start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("hold_max", 32'(max_val), 32'(v.emax));
    chk("hold_min", 32'(min_val), 32'(v.emin));
  endtask

  initial begin
    tbl[0] = '{d: {4'd5, 4'd6, 4'd3, 4'd2}, gap_at: -1, gap_len: 0,
               poke: 1'b0, gmax: 4'd0, gmin: 4'd0,
               emax: 4'd6, emin: 4'd2, emaxi: 2'd2, emini: 2'd0};
    tbl[1] = '{d: {4'd5, 4'd1, 4'd5, 4'd5}, gap_at: 1, gap_len: 2,
               poke: 1'b0, gmax: 4'd5, gmin: 4'd5,
               emax: 4'd5, emin: 4'd1,
               emaxi: TL ? 2'd3 : 2'd0, emini: 2'd2};
    tbl[2] = '{d: {4'd7, 4'd7, 4'd0, 4'd15}, gap_at: -1, gap_len: 0,
               poke: 1'b1, gmax: 4'd0, gmin: 4'd0,
               emax: 4'd15, emin: 4'd0, emaxi: 2'd0, emini: 2'd1};
    tbl[3] = '{d: {4'd4, 4'd4, 4'd4, 4'd4}, gap_at: -1, gap_len: 0,
               poke: 1'b0, gmax: 4'd0, gmin: 4'd0,
               emax: 4'd4, emin: 4'd4,
               emaxi: TL ? 2'd3 : 2'd0, emini: TL ? 2'd3 : 2'd0};

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_max", 32'(max_val), 0);
    chk("rst_min", 32'(min_val), 0);
    chk("rst_maxi", 32'(max_idx), 0);
    chk("rst_mini", 32'(min_idx), 0);
    chk("rst_busy1", 32'(busy1), 0);

    for (int k = 0; k < 3; k++) run_burst(k);

    // Abort a burst after two beats
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'd9;
    step();
    in_data  = 4'd1;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(in_ready), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_max", 32'(max_val), 0);
    chk("abort_min", 32'(min_val), 0);
    repeat (3) begin
      step();
      chk("abort_idle", 32'(busy | done), 0);
    end
    run_burst(3);
    chk("done_pulses", 32'(dcnt), 4);

    // COUNT=1 instance goes FIRST straight to DONE
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("c1_ready", 32'(in_ready1), 1);
    in_valid1 = 1'b1;
    in_data1  = 4'd9;
    step();
    in_valid1 = 1'b0;
    chk("c1_done", 32'(done1), 1);
    chk("c1_max", 32'(max_val1), 9);
    chk("c1_min", 32'(min_val1), 9);
    chk("c1_maxi", 32'(max_idx1), 0);
    chk("c1_mini", 32'(min_idx1), 0);
    step();
    chk("c1_post_done", 32'(done1), 0);
    chk("c1_post_busy", 32'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_minmax_seq.md
Name: cmp_minmax_seq

Overview:
- Sequencing controller that runs one magnitude comparator over a burst of COUNT samples and reports the running maximum and minimum with their indices.
- Sits between a sample source (valid/ready stream) and downstream logic that needs burst extremes.
- Time-shares a single internal compare unit: one sample is compared against max and min per accepted beat.
- Compare flags: gt (a>b), eq (a==b), lt (a<b).

Parameters:
- WIDTH, 4, sample width in bits, unsigned.
- COUNT, 4, samples per burst, legal range 1..256.
- IDXW, localparam = (COUNT>1) ? $clog2(COUNT) : 1, index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin a burst; sampled only in IDLE
- in_valid  input  1  sample present on in_data
- in_data  input  WIDTH  unsigned sample
- in_ready  output  1  block accepts a sample this cycle
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, results valid
- max_val  output  WIDTH  largest sample of last burst
- min_val  output  WIDTH  smallest sample of last burst
- max_idx  output  IDXW  index (0-based) of max_val
- min_idx  output  IDXW  index of min_val

Behaviour:
- All outputs registered.
- Reset: state=IDLE; in_ready=0, busy=0, done=0, max_val=0, min_val=0, max_idx=0, min_idx=0, internal count=0.
- FSM states: IDLE, FIRST, RUN, DONE.
- IDLE: in_ready=0. start=1 -> FIRST next cycle. start=0 -> stay.
- FIRST: in_ready=1, busy=1.
  - Beat accepted (in_valid && in_ready): max_val=min_val=in_data, both idx=0, count=1.
  - COUNT==1 -> DONE; else -> RUN.
- RUN: in_ready=1.
  - Each accepted beat compares in_data against max_val and against min_val in the same cycle.
  - gt vs max -> max_val/max_idx updated to in_data/count.
  - lt vs min -> min_val/min_idx updated.
  - eq: no update; earliest index wins ties.
  - count increments per beat.
  - Beat with count==COUNT-1 -> DONE.
  - in_valid=0: hold, no update.
- DONE: in_ready=0, done=1 for exactly one cycle, busy=1 -> IDLE.
  - Results hold until the next burst's first beat overwrites them.
- Latency: done asserts the cycle after the COUNT-th accepted beat. Minimum burst duration is COUNT+2 cycles from start.
- start outside IDLE is ignored, including start in DONE; no queuing.
- Back-to-back bursts: start may be asserted in the cycle done is high but is ignored. start in the following IDLE cycle is honoured.
- Single sample can be both max and min (all-equal burst -> max_idx=min_idx=0).
- Reset mid-burst: immediate return to IDLE with the reset values above; partial results are discarded; no done pulse.
- Arithmetic is unsigned; no wrap concerns. count width IDXW+1 so count reaches COUNT without overflow.

Optional Feature:
- Macro CMP_TIE_LAST_EN.
- Defined: on eq against current max (or min) in RUN, the index updates to the current count, so the latest occurrence wins ties. Values are unchanged.
- Undefined: ties keep the earliest index, as specified above. Port list is identical in both builds.

Test Plan:
- Reset then idle: rst=1 two cycles, then start=0 -> all outputs 0, in_ready=0, busy=0, no done.
- COUNT=4 burst 2,3,6,5 with in_valid continuous -> done one cycle after beat 4; max_val=6 max_idx=2, min_val=2 min_idx=0.
- COUNT=4 burst 5,5,1,5 with in_valid dropped for 2 cycles after beat 2 -> no update during gap. Default build: max_val=5 max_idx=0, min_val=1 min_idx=2. CMP_TIE_LAST_EN build: max_idx=3.
- start pulsed during RUN and during DONE -> ignored; one done per burst. A second start one cycle after done starts a new burst; beats 15,0,7,7 -> max 15/idx0, min 0/idx1.
- rst asserted after beat 2 of burst 9,1,... -> next cycle IDLE, outputs 0, no done. A following full burst 4,4,4,4 -> max=min=4, both idx 0.
- COUNT=1 build, start then in_data=9 -> FIRST->DONE directly; done pulses; max_val=min_val=9, idx 0.
